pix_interp: RTL and testbench

- Pixel stage directly downstream of the triangle rasterizer.
- Consumes one 299-bit rasterized-pixel word (pixel coordinates, three 80-bit vertex records, barycentric weights u/v).
- Interpolates depth and RGB, computes the framebuffer address, and buffers results in an output FIFO for the framebuffer/z-test stage.
- Fixed-latency 3-stage pipeline feeding a FIFO, with credit-style ready so a registered upstream valid pulse is never dropped.

---
 rtl/pix_interp.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_pix_interp.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pix_interp.sv
// -----------------------------------------------------------------------------
// pix_interp
//   Pixel stage that sits right after the triangle rasterizer. Each accepted
//   pixel word carries a screen position, three vertex records and the
//   barycentric weights u/v. The stage interpolates depth and RGB, forms the
//   framebuffer address and queues the result in a small output FIFO for the
//   framebuffer / z-test stage.
//
//   Pipeline (never stalls):
//     S0  capture pixel word, derive w0 = 1.0 - u - v (clamped at 0)
//     S1  twelve attribute x weight products
//     S2  sums, rounding, saturation, framebuffer address
//     FIFO write on the edge that ends S2
//
// Ports:
//   clk_i        clock
//   reset_n_i    synchronous reset, active low
//   pix_valid_i  one-cycle pulse, pix_data_i holds a pixel word
//   pix_ready_o  room is guaranteed for a pixel arriving on the next cycle
//   pix_data_i   {x[298:290], y[289:282], v2[281:202], v1[201:122],
//                 v0[121:42], u[41:21], v[20:0]}
//   out_valid_o  FIFO head valid
//   out_ready_i  downstream accepts the head
//   out_x_o      pixel x
//   out_y_o      pixel y
//   out_z_o      interpolated depth
//   out_rgb_o    interpolated {r,g,b}
//   out_addr_o   y*H_RES + x, truncated to 17 bits
//   overflow_o   sticky: a result reached a full FIFO and was dropped
// -----------------------------------------------------------------------------
module pix_interp #(
    parameter int FIFO_DEPTH = 8,
    parameter int H_RES      = 320,
    parameter int WFRAC      = 20
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    input  logic          pix_valid_i,
    output logic          pix_ready_o,
    input  logic [298:0]  pix_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [8:0]    out_x_o,
    output logic [7:0]    out_y_o,
    output logic [15:0]   out_z_o,
    output logic [23:0]   out_rgb_o,
    output logic [16:0]   out_addr_o,
    output logic          overflow_o
);

    localparam int AW = $clog2(FIFO_DEPTH);   // pointer width
    localparam int CW = AW + 1;               // FIFO count width
    localparam int OW = AW + 2;               // count + in-flight width
    localparam int WW = 21;                   // weight width (Q1.WFRAC)
    localparam int PW = 40;                   // product / sum width

    localparam logic signed [22:0] ONE_C      = 23'sd1 <<< WFRAC;
    localparam logic [PW-1:0]      RND_C      = {{(PW-1){1'b0}}, 1'b1} << (WFRAC - 1);
    localparam logic [31:0]        H_RES_C    = 32'(H_RES);
    localparam logic [CW-1:0]      FULL_C     = CW'(FIFO_DEPTH);
    localparam logic [OW-1:0]      READY_LIM_C = OW'(FIFO_DEPTH - 2);

    typedef struct packed {
        logic [8:0]  x;
        logic [7:0]  y;
        logic [15:0] z;
        logic [23:0] rgb;
        logic [16:0] addr;
    } res_t;

    // Attribute index: 0 = z (16 bit), 1 = r, 2 = g, 3 = b (8 bit, zero-extended).
    // A vertex is carried as its upper 40 bits {z, r, g, b}; the rest is unused.
    function automatic logic [15:0] attr_of(input logic [39:0] vtx, input int idx);
        logic [15:0] a_v;
        case (idx)
            0:       a_v = vtx[39:24];
            1:       a_v = {8'd0, vtx[23:16]};
            2:       a_v = {8'd0, vtx[15:8]};
            3:       a_v = {8'd0, vtx[7:0]};
            default: a_v = 16'd0;
        endcase
        return a_v;
    endfunction

    function automatic logic [PW-1:0] mul_w(input logic [15:0] a, input logic [WW-1:0] w);
        return PW'(a) * PW'(w);
    endfunction

    // Weighted sum, round half up at the binary point, clip to the field max.
    function automatic logic [15:0] round_sat(input logic [PW-1:0] p0,
                                              input logic [PW-1:0] p1,
                                              input logic [PW-1:0] p2,
                                              input logic [15:0]   max_v);
        logic [PW-1:0] sum_v;
        logic [PW-1:0] shr_v;
        logic [15:0]   res_v;
        sum_v = p0 + p1 + p2 + RND_C;
        shr_v = sum_v >> WFRAC;
        if (shr_v > PW'(max_v)) begin
            res_v = max_v;
        end else begin
            res_v = shr_v[15:0];
        end
        return res_v;
    endfunction

    // ------------------------------------------------------------------ S0 ---
    logic                  s0_valid_r;
    logic [8:0]            s0_x_r;
    logic [7:0]            s0_y_r;
    logic [39:0]           s0_vtx_r [3];
    logic [WW-1:0]         s0_w_r   [3];   // [0]=w0, [1]=u, [2]=v

    logic signed [22:0]    w0_diff_s;
    logic [WW-1:0]         w0_clamp_s;

    // w0 = 1.0 - u - v; a negative result means the point is outside the
    // triangle in v0's direction, so its weight is simply zeroed.
    always_comb begin
        w0_diff_s = ONE_C - $signed({2'b00, pix_data_i[41:21]})
                          - $signed({2'b00, pix_data_i[20:0]});
        if (w0_diff_s[22]) begin
            w0_clamp_s = '0;
        end else begin
            w0_clamp_s = w0_diff_s[WW-1:0];
        end
    end

    // S0 register: capture pixel word and weights on every valid pulse.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            s0_valid_r <= 1'b0;
            s0_x_r     <= 9'd0;
            s0_y_r     <= 8'd0;
            for (int i = 0; i < 3; i++) begin
                s0_vtx_r[i] <= 40'd0;
                s0_w_r[i]   <= '0;
            end
        end else begin
            s0_valid_r <= pix_valid_i;
            if (pix_valid_i) begin
                s0_x_r      <= pix_data_i[298:290];
                s0_y_r      <= pix_data_i[289:282];
                s0_vtx_r[2] <= pix_data_i[281:242];
                s0_vtx_r[1] <= pix_data_i[201:162];
                s0_vtx_r[0] <= pix_data_i[121:82];
                s0_w_r[0]   <= w0_clamp_s;
                s0_w_r[1]   <= pix_data_i[41:21];
                s0_w_r[2]   <= pix_data_i[20:0];
            end
        end
    end

    // ------------------------------------------------------------------ S1 ---
    logic                  s1_valid_r;
    logic [8:0]            s1_x_r;
    logic [7:0]            s1_y_r;
    logic [PW-1:0]         s1_prod_r [3][4];   // [vertex][attribute]

    // S1 register: vertex attribute times its barycentric weight.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            s1_valid_r <= 1'b0;
            s1_x_r     <= 9'd0;
            s1_y_r     <= 8'd0;
            for (int vi = 0; vi < 3; vi++) begin
                for (int ai = 0; ai < 4; ai++) begin
                    s1_prod_r[vi][ai] <= '0;
                end
            end
        end else begin
            s1_valid_r <= s0_valid_r;
            s1_x_r     <= s0_x_r;
            s1_y_r     <= s0_y_r;
            for (int vi = 0; vi < 3; vi++) begin
                for (int ai = 0; ai < 4; ai++) begin
                    s1_prod_r[vi][ai] <= mul_w(attr_of(s0_vtx_r[vi], ai), s0_w_r[vi]);
                end
            end
        end
    end

    // ------------------------------------------------------------------ S2 ---
    logic                  s2_valid_r;
    res_t                  s2_res_r;
    res_t                  s2_res_s;
    logic [31:0]           addr_full_s;
    logic [15:0]           col_s [3];

    // Final attribute values and framebuffer address from the S1 products.
    always_comb begin
        for (int ai = 1; ai < 4; ai++) begin
            col_s[ai-1] = round_sat(s1_prod_r[0][ai], s1_prod_r[1][ai],
                                    s1_prod_r[2][ai], 16'h00FF);
        end
        addr_full_s    = ({24'd0, s1_y_r} * H_RES_C) + {23'd0, s1_x_r};
        s2_res_s.x     = s1_x_r;
        s2_res_s.y     = s1_y_r;
        s2_res_s.z     = round_sat(s1_prod_r[0][0], s1_prod_r[1][0],
                                   s1_prod_r[2][0], 16'hFFFF);
        s2_res_s.rgb   = {col_s[0][7:0], col_s[1][7:0], col_s[2][7:0]};
        s2_res_s.addr  = addr_full_s[16:0];
    end

    // S2 register: finished result waiting for the FIFO write.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            s2_valid_r <= 1'b0;
            s2_res_r   <= '0;
        end else begin
            s2_valid_r <= s1_valid_r;
            s2_res_r   <= s2_res_s;
        end
    end

    // ---------------------------------------------------------------- FIFO ---
    res_t                  fifo_mem_r [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic                  overflow_r;

    logic                  push_s;
    logic                  pop_s;
    logic                  full_s;
    logic                  wr_en_s;
    logic                  drop_s;
    logic [1:0]            inflight_s;
    logic [OW-1:0]         occ_s;

    // FIFO control. At full a push is still taken when a pop frees the slot
    // in the same cycle; otherwise the result is dropped and flagged.
    always_comb begin
        push_s     = s2_valid_r;
        pop_s      = (count_r != '0) && out_ready_i;
        full_s     = (count_r == FULL_C);
        wr_en_s    = push_s && (!full_s || pop_s);
        drop_s     = push_s && full_s && !pop_s;
        inflight_s = {1'b0, s0_valid_r} + {1'b0, s1_valid_r} + {1'b0, s2_valid_r};
        occ_s      = OW'(count_r) + OW'(inflight_s);
        // One slot of slack: the upstream valid is registered, so one more
        // pulse can land after ready falls.
        pix_ready_o = (occ_s <= READY_LIM_C);
    end

    // FIFO storage write; contents are never read while the count is zero.
    always_ff @(posedge clk_i) begin
        if (reset_n_i && wr_en_s) begin
            fifo_mem_r[wr_ptr_r] <= s2_res_r;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_en_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Output head, forced to zero while the FIFO is empty.
    always_comb begin
        out_valid_o = (count_r != '0);
        overflow_o  = overflow_r;
        if (out_valid_o) begin
            out_x_o    = fifo_mem_r[rd_ptr_r].x;
            out_y_o    = fifo_mem_r[rd_ptr_r].y;
            out_z_o    = fifo_mem_r[rd_ptr_r].z;
            out_rgb_o  = fifo_mem_r[rd_ptr_r].rgb;
            out_addr_o = fifo_mem_r[rd_ptr_r].addr;
        end else begin
            out_x_o    = 9'd0;
            out_y_o    = 8'd0;
            out_z_o    = 16'd0;
            out_rgb_o  = 24'd0;
            out_addr_o = 17'd0;
        end
    end

endmodule

// File: tb/tb_pix_interp.sv
module tb_pix_interp;

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic          pix_valid_i;
    logic          pix_ready_o;
    logic [298:0]  pix_data_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [8:0]    out_x_o;
    logic [7:0]    out_y_o;
    logic [15:0]   out_z_o;
    logic [23:0]   out_rgb_o;
    logic [16:0]   out_addr_o;
    logic          overflow_o;

    typedef struct packed {
        logic [8:0]  x;
        logic [7:0]  y;
        logic [15:0] z;
        logic [23:0] rgb;
        logic [16:0] addr;
    } res_t;

    res_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    pix_interp #(.FIFO_DEPTH(8), .H_RES(320), .WFRAC(20)) dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .pix_valid_i (pix_valid_i),
        .pix_ready_o (pix_ready_o),
        .pix_data_i  (pix_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_x_o     (out_x_o),
        .out_y_o     (out_y_o),
        .out_z_o     (out_z_o),
        .out_rgb_o   (out_rgb_o),
        .out_addr_o  (out_addr_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] vtx(input logic [15:0] z, input logic [7:0] r,
                                        input logic [7:0] g, input logic [7:0] b);
        return {z, r, g, b, 40'hA5_5A3C_C3F0};
    endfunction

    function automatic longint attr(input longint a0, input longint a1, input longint a2,
                                    input longint w0, input longint u, input longint v,
                                    input longint mx);
        longint s;
        s = (a0 * w0 + a1 * u + a2 * v + 64'sd524288) / 64'sd1048576;
        if (s > mx) s = mx;
        return s;
    endfunction

    function automatic res_t model(input logic [8:0] x, input logic [7:0] y,
                                   input logic [79:0] a0, input logic [79:0] a1,
                                   input logic [79:0] a2, input logic [20:0] u,
                                   input logic [20:0] v);
        res_t   r;
        longint w0, lu, lv, ad, rr, gg, bb, zz;
        lu = longint'(u);
        lv = longint'(v);
        w0 = 64'sd1048576 - lu - lv;
        if (w0 < 0) w0 = 0;
        zz = attr(longint'(a0[79:64]), longint'(a1[79:64]), longint'(a2[79:64]), w0, lu, lv, 65535);
        rr = attr(longint'(a0[63:56]), longint'(a1[63:56]), longint'(a2[63:56]), w0, lu, lv, 255);
        gg = attr(longint'(a0[55:48]), longint'(a1[55:48]), longint'(a2[55:48]), w0, lu, lv, 255);
        bb = attr(longint'(a0[47:40]), longint'(a1[47:40]), longint'(a2[47:40]), w0, lu, lv, 255);
        ad = longint'(y) * 320 + longint'(x);
        r.x    = x;
        r.y    = y;
        r.z    = zz[15:0];
        r.rgb  = {rr[7:0], gg[7:0], bb[7:0]};
        r.addr = ad[16:0];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drive one pulse; the accepting edge is the one this task waits on.
    task automatic send(input logic [8:0] x, input logic [7:0] y, input logic [79:0] a0,
                        input logic [79:0] a1, input logic [79:0] a2,
                        input logic [20:0] u, input logic [20:0] v, input bit track);
        pix_data_i  = {x, y, a2, a1, a0, u, v};
        pix_valid_i = 1'b1;
        if (track) sb_q.push_back(model(x, y, a0, a1, a2, u, v));
        tick();
        pix_valid_i = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int c = 0;
        while (!out_valid_o && c < budget) begin
            tick();
            c++;
        end
        chk("wait_valid", out_valid_o, 1'b1);
    endtask

    // Pop n results, comparing each head against the scoreboard front.
    task automatic drain(input int n, input int budget);
        int   got = 0;
        int   cyc = 0;
        res_t e;
        out_ready_i = 1'b1;
        while (got < n && cyc < budget) begin
            if (out_valid_o) begin
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("pop_result", {out_x_o, out_y_o, out_z_o, out_rgb_o, out_addr_o}, e);
                end else begin
                    n_err++;
                    $error("FAIL sb_underflow observed=result expected=none");
                end
                got++;
            end
            tick();
            cyc++;
        end
        out_ready_i = 1'b0;
        chk("drain_count", got, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [79:0] a0, a1, a2, c0, c1, c2, r0, r1, r2;
        int sent;

        reset_n_i   = 1'b0;
        pix_valid_i = 1'b0;
        pix_data_i  = '0;
        out_ready_i = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", out_valid_o, 1'b0);
        chk("rst_overflow",  overflow_o, 1'b0);
        chk("rst_pix_ready", pix_ready_o, 1'b1);
        chk("rst_data",      {out_x_o, out_y_o, out_z_o, out_rgb_o, out_addr_o}, 74'd0);
        reset_n_i = 1'b1;
        tick();

        a0 = vtx(16'h1000, 8'd100, 8'd10, 8'd20);
        a1 = vtx(16'h2000, 8'd200, 8'd30, 8'd40);
        a2 = vtx(16'h3000, 8'd40,  8'd50, 8'd60);

        // Corner weight at v0, with latency check.
        send(9'd10, 8'd20, a0, a1, a2, 21'h0, 21'h0, 1'b1);
        tick();
        tick();
        chk("lat0_e2_valid", out_valid_o, 1'b0);
        tick();
        chk("lat0_e3_valid", out_valid_o, 1'b1);
        chk("corner0_z", out_z_o, 16'h1000);
        chk("corner0_r", out_rgb_o[23:16], 8'd100);
        drain(1, 10);

        // Corner weight at v1.
        send(9'd11, 8'd21, a0, a1, a2, 21'h100000, 21'h0, 1'b1);
        tick();
        tick();
        chk("lat1_e2_valid", out_valid_o, 1'b0);
        tick();
        chk("lat1_e3_valid", out_valid_o, 1'b1);
        chk("corner1_z", out_z_o, 16'h2000);
        chk("corner1_r", out_rgb_o[23:16], 8'd200);
        drain(1, 10);

        // Mixed weights.
        send(9'd12, 8'd22, a0, a1, a2, 21'h040000, 21'h040000, 1'b1);
        wait_valid(10);
        chk("mixed_z", out_z_o, 16'h1C00);
        chk("mixed_r", out_rgb_o[23:16], 8'd110);
        drain(1, 10);

        // w0 clamp and saturation.
        c0 = vtx(16'h0000, 8'd0,   8'd0, 8'd0);
        c1 = vtx(16'hF000, 8'd200, 8'd1, 8'd2);
        c2 = vtx(16'hF000, 8'd200, 8'd3, 8'd4);
        send(9'd13, 8'd23, c0, c1, c2, 21'h0C0000, 21'h0C0000, 1'b1);
        wait_valid(10);
        chk("clamp_z", out_z_o, 16'hFFFF);
        chk("clamp_r", out_rgb_o[23:16], 8'd255);
        drain(1, 10);

        // Address corners, back to back.
        send(9'd319, 8'd239, a0, a1, a2, 21'h020000, 21'h010000, 1'b1);
        send(9'd0,   8'd0,   a0, a1, a2, 21'h010000, 21'h020000, 1'b1);
        wait_valid(10);
        chk("addr_max", out_addr_o, 17'd76799);
        drain(1, 10);
        chk("addr_zero_valid", out_valid_o, 1'b1);
        chk("addr_zero", out_addr_o, 17'd0);
        drain(1, 10);

        // Burst of pseudo-random pixels, rounding and clamp mixes.
        for (int i = 0; i < 6; i++) begin
            r0 = vtx(16'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            r1 = vtx(16'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            r2 = vtx(16'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            send(9'($urandom), 8'($urandom), r0, r1, r2,
                 21'($urandom_range(0, 21'h0C0000)), 21'($urandom_range(0, 21'h0C0000)), 1'b1);
        end
        drain(6, 30);

        // Backpressure: fill while ready, then one more pulse of slack.
        sent = 0;
        for (int i = 0; i < 20; i++) begin
            if (!pix_ready_o) break;
            send(9'(i + 100), 8'(i * 3), a0, a1, a2, 21'(i * 32'h10000), 21'h008000, 1'b1);
            sent++;
        end
        chk("ready_drop_count", sent, 7);
        chk("ready_low", pix_ready_o, 1'b0);
        send(9'd200, 8'd50, a0, a1, a2, 21'h0, 21'h080000, 1'b1);
        tick(); tick(); tick(); tick();
        chk("full_overflow0", overflow_o, 1'b0);
        chk("full_valid", out_valid_o, 1'b1);

        // Ninth result at full: dropped, flagged, FIFO untouched.
        send(9'd201, 8'd51, a0, a1, a2, 21'h0, 21'h0, 1'b0);
        tick(); tick(); tick();
        chk("overflow_set", overflow_o, 1'b1);
        drain(8, 40);
        chk("drain_empty", out_valid_o, 1'b0);
        chk("overflow_sticky", overflow_o, 1'b1);

        // Reset in the middle of traffic.
        for (int i = 0; i < 4; i++) begin
            send(9'(i), 8'(i), a0, a1, a2, 21'h0, 21'h0, 1'b0);
        end
        chk("pre_reset_valid", out_valid_o, 1'b1);
        reset_n_i   = 1'b0;
        out_ready_i = 1'b1;
        tick();
        reset_n_i   = 1'b1;
        out_ready_i = 1'b0;
        chk("mid_rst_valid", out_valid_o, 1'b0);
        chk("mid_rst_overflow", overflow_o, 1'b0);
        chk("mid_rst_ready", pix_ready_o, 1'b1);
        chk("mid_rst_addr", out_addr_o, 17'd0);
        tick(); tick(); tick(); tick();
        chk("post_rst_flushed", out_valid_o, 1'b0);

        // Normal operation afterwards.
        send(9'd5, 8'd6, a0, a1, a2, 21'h030000, 21'h050000, 1'b1);
        wait_valid(10);
        drain(1, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
